// File: rtl/load_store_unit_if.sv
// Core request/response handshake plus the byte-wide data-memory port of the
// load/store sequencer, bundled so the core side and the memory side travel together.
interface load_store_unit_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic        ready;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic [7:0]  mem_a;
   logic [7:0]  mem_wd;
   logic        mem_we;
   logic [7:0]  mem_rd;

   modport master (
      output req, we, size, uns, addr, wdata, mem_rd,
      input  ready, done, err, rdata, mem_a, mem_wd, mem_we
   );

   modport slave (
      input  req, we, size, uns, addr, wdata, mem_rd,
      output ready, done, err, rdata, mem_a, mem_wd, mem_we
   );
endinterface

// File: rtl/load_store_unit.sv
// Splits byte/half/word loads and stores into little-endian single-byte accesses
// on an 8-bit, 256-entry memory; assembles and extends load results.
module load_store_unit (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        done_q, done_d;
   logic [31:0] rdata_q, rdata_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [23:0] buf_q, buf_d;
   logic [31:0] buf_full;
   logic [1:0]  last_cnt;

   function automatic logic bad_req(input logic [1:0] sz, input logic [7:0] a);
      bad_req = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] b, input logic [1:0] sz,
                                               input logic u);
      case (sz)
         2'b00:   extend_load = {{24{b[7] & ~u}}, b[7:0]};
         2'b01:   extend_load = {{16{b[15] & ~u}}, b[15:0]};
         default: extend_load = b;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

   // Request fields and the load buffer only matter once a request is accepted.
   always_ff @(posedge clk) begin
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      done_d   = 1'b0;
      rdata_d  = rdata_q;
      we_d     = we_q;
      size_d   = size_q;
      uns_d    = uns_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      buf_d    = buf_q;
      last_cnt = {size_q[1], size_q[1] | size_q[0]};
      // The final byte is merged straight from mem_rd so rdata can update on the last edge.
      buf_full = {8'd0, buf_q};
      buf_full[{cnt_q, 3'b000} +: 8] = bus.mem_rd;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               size_d  = bus.size;
               uns_d   = bus.uns;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               cnt_d   = 2'd0;
               err_d   = bad_req(bus.size, bus.addr);
               if (bad_req(bus.size, bus.addr)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = XFER;
               end
            end
         end
         XFER: begin
            cnt_d = cnt_q + 2'd1;
            if (!we_q) buf_d = buf_full[23:0];
            if (cnt_q == last_cnt) begin
               state_d = DONE;
               done_d  = 1'b1;
               if (!we_q) rdata_d = extend_load(buf_full, size_q, uns_q);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.ready  = (state_q == IDLE);
      bus.done   = done_q;
      bus.err    = err_q;
      bus.rdata  = rdata_q;
      bus.mem_we = 1'b0;
      bus.mem_a  = 8'd0;
      bus.mem_wd = 8'd0;
      if (state_q == XFER) begin
         bus.mem_a  = addr_q + {6'd0, cnt_q};
         bus.mem_we = we_q;
         if (we_q) bus.mem_wd = wdata_q[{cnt_q, 3'b000} +: 8];
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected completions,
// a monitor pops them on each done pulse and checks result, error flag and latency.
module tb_load_store_unit;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   logic clk;
   logic rst;
   load_store_unit_if ifc();

   logic [7:0] mem [256];
   exp_t       exp_q[$];
   int         acc_q[$];
   int         cyc;
   int         wr_cnt;
   int         acc_cnt;
   int         last_acc;
   int         prev_acc;
   int         total;
   int         bad;

   load_store_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   assign ifc.mem_rd = mem[ifc.mem_a];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
      total++;
      if (act !== req_v) begin
         bad++;
         $display("FAIL %s: got %h, required %h", nm, act, req_v);
      end
   endtask

   // Edge bookkeeping: cycle count, accepted requests, memory writes.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst && ifc.req && ifc.ready) begin
         acc_q.push_back(cyc);
         acc_cnt++;
         prev_acc = last_acc;
         last_acc = cyc;
      end
      if (ifc.mem_we) begin
         mem[ifc.mem_a] <= ifc.mem_wd;
         wr_cnt++;
      end
   end

   always @(negedge clk) begin
      if (rst && ifc.done) begin
         if (exp_q.size() == 0 || acc_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            int   a;
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            chk("done_err", {31'd0, ifc.err}, {31'd0, e.err});
            chk("done_rdata", ifc.rdata, e.rdata);
            chk("done_latency", cyc, a + e.lat);
         end
      end
   end

   task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                        input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                        input int lat, input bit push);
      int k;
      exp_t e;
      k = 0;
      @(negedge clk);
      while (!ifc.ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) chk("ready_timeout", 32'd0, 32'd1);
      ifc.req   = 1'b1;
      ifc.we    = w;
      ifc.size  = sz;
      ifc.uns   = u;
      ifc.addr  = a;
      ifc.wdata = wd;
      if (push) begin
         e.err   = e_err;
         e.rdata = e_rd;
         e.lat   = lat;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      ifc.req = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 30) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
         acc_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int a0;
      total = 0; bad = 0; cyc = 0; wr_cnt = 0; acc_cnt = 0; last_acc = 0; prev_acc = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h22] = 8'hEE;
      mem[8'h23] = 8'hEE;

      // Reset with a store request held high.
      rst = 1'b0; ifc.req = 1'b1; ifc.we = 1'b1; ifc.size = 2'b10; ifc.uns = 1'b0;
      ifc.addr = 8'h00; ifc.wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_ready", {31'd0, ifc.ready}, 32'd1);
         chk("rst_done", {31'd0, ifc.done}, 32'd0);
         chk("rst_err", {31'd0, ifc.err}, 32'd0);
         chk("rst_rdata", ifc.rdata, 32'd0);
         chk("rst_mem_we", {31'd0, ifc.mem_we}, 32'd0);
         chk("rst_mem_a", {24'd0, ifc.mem_a}, 32'd0);
         chk("rst_mem_wd", {24'd0, ifc.mem_wd}, 32'd0);
      end
      ifc.req = 1'b0;
      rst = 1'b1;
      chk("rst_no_write", wr_cnt, 32'd0);
      chk("rst_no_accept", acc_cnt, 32'd0);

      // Word store and the image it leaves.
      issue(1'b1, 2'b10, 1'b0, 8'h10, 32'hA1B2C3D4, 1'b0, 32'h0, 4, 1'b1);
      drain();
      chk("store_w_count", wr_cnt, 32'd4);
      chk("mem10", {24'd0, mem[8'h10]}, 32'hD4);
      chk("mem11", {24'd0, mem[8'h11]}, 32'hC3);
      chk("mem12", {24'd0, mem[8'h12]}, 32'hB2);
      chk("mem13", {24'd0, mem[8'h13]}, 32'hA1);

      // Loads with sign and zero extension.
      issue(1'b0, 2'b00, 1'b0, 8'h13, 32'h0, 1'b0, 32'hFFFFFFA1, 1, 1'b1); drain();
      issue(1'b0, 2'b00, 1'b1, 8'h13, 32'h0, 1'b0, 32'h000000A1, 1, 1'b1); drain();
      issue(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, 1'b0, 32'hFFFFA1B2, 2, 1'b1); drain();
      issue(1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 1'b0, 32'h0000A1B2, 2, 1'b1); drain();
      issue(1'b0, 2'b01, 1'b0, 8'h10, 32'h0, 1'b0, 32'hFFFFC3D4, 2, 1'b1); drain();
      issue(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0, 32'hA1B2C3D4, 4, 1'b1); drain();

      // Byte/half stores, positive sign bit, mixed word readback.
      issue(1'b1, 2'b00, 1'b0, 8'h30, 32'h0000007F, 1'b0, 32'hA1B2C3D4, 1, 1'b1); drain();
      issue(1'b0, 2'b00, 1'b0, 8'h30, 32'h0, 1'b0, 32'h0000007F, 1, 1'b1); drain();
      issue(1'b1, 2'b01, 1'b0, 8'h32, 32'h00008001, 1'b0, 32'h0000007F, 2, 1'b1); drain();
      issue(1'b0, 2'b01, 1'b0, 8'h32, 32'h0, 1'b0, 32'hFFFF8001, 2, 1'b1); drain();
      issue(1'b0, 2'b10, 1'b0, 8'h30, 32'h0, 1'b0, 32'h8001007F, 4, 1'b1); drain();

      // Misaligned and illegal requests: no memory traffic, rdata kept.
      w0 = wr_cnt;
      issue(1'b0, 2'b01, 1'b0, 8'h11, 32'h0, 1'b1, 32'h8001007F, 0, 1'b1); drain();
      issue(1'b0, 2'b11, 1'b0, 8'h00, 32'h0, 1'b1, 32'h8001007F, 0, 1'b1); drain();
      issue(1'b1, 2'b10, 1'b0, 8'h12, 32'hDEADBEEF, 1'b1, 32'h8001007F, 0, 1'b1); drain();
      chk("err_no_write", wr_cnt, w0);
      chk("err_mem12", {24'd0, mem[8'h12]}, 32'hB2);

      // A store request raised while busy must be dropped.
      w0 = wr_cnt; a0 = acc_cnt;
      issue(1'b0, 2'b00, 1'b1, 8'h11, 32'h0, 1'b0, 32'h000000C3, 1, 1'b1);
      ifc.req = 1'b1; ifc.we = 1'b1; ifc.size = 2'b00; ifc.addr = 8'h40; ifc.wdata = 32'h55;
      @(posedge clk);
      @(negedge clk);
      ifc.req = 1'b0;
      drain();
      chk("busy_accepts", acc_cnt - a0, 32'd1);
      chk("busy_no_write", wr_cnt, w0);
      chk("busy_mem40", {24'd0, mem[8'h40]}, 32'h00);

      // Back-to-back word loads with req held.
      @(negedge clk);
      a0 = acc_cnt;
      ifc.req = 1'b1; ifc.we = 1'b0; ifc.size = 2'b10; ifc.uns = 1'b0; ifc.addr = 8'h10;
      begin
         exp_t e;
         e.err = 1'b0; e.rdata = 32'hA1B2C3D4; e.lat = 4;
         exp_q.push_back(e);
         exp_q.push_back(e);
      end
      for (int k = 0; k < 30 && acc_cnt < a0 + 2; k++) @(negedge clk);
      ifc.req = 1'b0;
      chk("b2b_accepts", acc_cnt - a0, 32'd2);
      chk("b2b_spacing", last_acc - prev_acc, 32'd6);
      drain();

      // Reset in cycle E+2 of a word store.
      issue(1'b1, 2'b10, 1'b0, 8'h20, 32'h11223344, 1'b0, 32'h0, 4, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_ready", {31'd0, ifc.ready}, 32'd1);
      chk("mid_rst_mem_we", {31'd0, ifc.mem_we}, 32'd0);
      chk("mid_rst_rdata", ifc.rdata, 32'd0);
      acc_q.delete();
      rst = 1'b1;
      repeat (6) @(negedge clk);
      chk("mid_rst_mem20", {24'd0, mem[8'h20]}, 32'h44);
      chk("mid_rst_mem21", {24'd0, mem[8'h21]}, 32'h33);
      chk("mid_rst_mem22", {24'd0, mem[8'h22]}, 32'hEE);
      chk("mid_rst_mem23", {24'd0, mem[8'h23]}, 32'hEE);

      // Normal operation resumes after the abort.
      issue(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 1'b0, 32'hEEEE3344, 4, 1'b1); drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the core datapath and the 8-bit-wide, 256-entry data memory. It turns one byte, halfword or word load/store request into 1, 2 or 4 consecutive single-byte memory accesses, in little-endian order. For loads it assembles and sign/zero-extends the 32-bit result. Misaligned and illegal requests are rejected without touching memory.

## Interface
Parameters:
- none; address width fixed at 8, memory data width at 8, core data width at 32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- req  in  1  core request; accepted only on an edge where ready=1.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- uns  in  1  load zero-extend (1) / sign-extend (0); ignored for stores.
- addr  in  8  byte address of the lowest byte.
- wdata  in  32  store data; byte k goes to addr+k.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: request was misaligned or illegal.
- rdata  out  32  load result; held until the next completed load.
- mem_a  out  8  memory address.
- mem_wd  out  8  memory write data.
- mem_we  out  1  memory write enable.
- mem_rd  in  8  memory read data; combinational from mem_a.

## Operation
- States: IDLE, XFER, DONE.
- IDLE: ready=1. On an edge with req=1:
  - latch we, size, uns, addr and wdata;
  - clear byte counter cnt to 0;
  - clear err.
- Validity check at accept:
  - size=11 is illegal;
  - size=01 is misaligned if addr[0]=1;
  - size=10 is misaligned if addr[1:0]≠00.
  - Illegal or misaligned: go to DONE with err=1 and no memory access. rdata is unchanged.
  - Otherwise go to XFER.
- XFER: n = 1/2/4 bytes for byte/half/word.
  - mem_a = latched addr + cnt. Alignment guarantees no 8-bit wrap.
  - Store: mem_we=1, mem_wd = wdata[8*cnt+7 : 8*cnt].
  - Load: mem_we=0; mem_rd is captured into byte cnt of an internal buffer on each edge.
  - cnt increments each edge; after the edge with cnt=n-1, go to DONE.
- DONE: done=1 and ready=0 for exactly one cycle, then IDLE.
  - On a successful load, rdata is updated on the edge entering DONE:
    - byte: buffer[7:0], extended from bit 7;
    - half: buffer[15:0], extended from bit 15;
    - word: buffer as-is;
    - uns=1 zero-extends, uns=0 sign-extends.
  - Stores and errored requests leave rdata unchanged.
- Outside XFER: mem_we=0, mem_a=0, mem_wd=0.
- req while ready=0 is ignored and not queued. Inputs other than req are don't-care outside the accept edge.

## Timing
- Reset (rst=0 at an edge) forces:
  - state=IDLE, cnt=0, rdata=0, err=0;
  - done=0, mem_we=0, mem_a=0, mem_wd=0;
  - ready=1 from the cycle after that edge.
- Reset mid-XFER aborts immediately: no further writes, no done pulse. Bytes already written stay in memory; this block never clears memory.
- Latency, with accept at edge E:
  - XFER occupies cycles E+1 … E+n;
  - done is high in cycle E+n+1;
  - ready is high again in cycle E+n+2.
- Throughput: one request per n+2 cycles.
- Errored request: done+err high in cycle E+1, ready in E+2.
- done and err are registered outputs; mem_* are decoded from registered state, so glitch-free at the edge.

## Test plan
- Reset with req=1 held: no accept while rst=0; all outputs 0 except ready=1 after the first reset edge; mem_we never asserts.
- Word store, addr=0x10, wdata=0xA1B2C3D4 → mem_we high 4 cycles, mem_a/mem_wd = 10/D4, 11/C3, 12/B2, 13/A1; done in cycle E+5, err=0.
- Loads from that image:
  - byte load addr=0x13, uns=0 → rdata=0xFFFFFFA1;
  - same with uns=1 → 0x000000A1;
  - half load addr=0x12, uns=0 → 0xFFFFA1B2;
  - word load addr=0x10 → 0xA1B2C3D4 with done at E+5.
- Misaligned/illegal:
  - half at 0x11 → done+err at E+1, mem_we never high, rdata unchanged;
  - size=11 at 0x00 → same behaviour.
- Reset asserted in cycle E+2 of a word store to 0x20 (wdata=0x11223344) → only 0x20=44 and 0x21=33 written; no done; ready=1 after reset.
- Back-to-back: req held high across two word loads → second accept exactly at E+6; req pulses during busy cycles are ignored.
